// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and FSM encoding for the register-file write-port arbiter.
// The hazard unit decodes pipe_stall causes from the same state constants.
package wb_port_arbiter_pkg;

   localparam int WB_DSIZE = 32;
   localparam int WB_ASIZE = 5;

   localparam logic ARB_NORMAL = 1'b0;
   localparam logic ARB_STALL  = 1'b1;

   typedef enum logic {
      ST_NORMAL = ARB_NORMAL,
      ST_STALL  = ARB_STALL
   } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline writeback, functional-unit result and register-file write signals.
// master = the side that produces results; slave = the arbiter.
interface wb_port_arbiter_if
   import wb_port_arbiter_pkg::*;
#(
   parameter int DSIZE = WB_DSIZE,
   parameter int ASIZE = WB_ASIZE
);

   logic             a_valid;
   logic [ASIZE-1:0] a_waddr;
   logic [DSIZE-1:0] a_wdata;

   logic             b_valid;
   logic             b_ready;
   logic [ASIZE-1:0] b_waddr;
   logic [DSIZE-1:0] b_wdata;

   logic             pipe_stall;

   logic             rf_wen;
   logic [ASIZE-1:0] rf_waddr;
   logic [DSIZE-1:0] rf_wdata;

   modport master (
      output a_valid, a_waddr, a_wdata,
      output b_valid, b_waddr, b_wdata,
      input  b_ready, pipe_stall,
      input  rf_wen, rf_waddr, rf_wdata
   );

   modport slave (
      input  a_valid, a_waddr, a_wdata,
      input  b_valid, b_waddr, b_wdata,
      output b_ready, pipe_stall,
      output rf_wen, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO holding functional-unit results until the write port is free.
// No bypass: a pushed entry becomes visible at the head on the following cycle.
module wb_skid_fifo #(
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign head_o  = mem_q[rd_ptr_q];

   // NOTE: every variable gets a default first so always_comb never infers a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: storage is deliberately not reset; count_q alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (A, priority) and a
// long-latency unit (B, buffered); a starvation counter forces a one-cycle stall for B.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DSIZE      = WB_DSIZE,
   parameter int ASIZE      = WB_ASIZE,
   parameter int STARVE_MAX = 4
) (
   input logic              clk,
   input logic              rst,
   wb_port_arbiter_if.slave bus
);

   typedef struct packed {
      logic [ASIZE-1:0] addr;
      logic [DSIZE-1:0] data;
   } wb_entry_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   wb_entry_t        push_entry;
   wb_entry_t        head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   arb_state_e       state_q, state_d;
   logic [3:0]       starve_q, starve_d;
   logic             rf_wen_q, rf_wen_d;
   logic [ASIZE-1:0] rf_waddr_q, rf_waddr_d;
   logic [DSIZE-1:0] rf_wdata_q, rf_wdata_d;

   logic             grant_a;
   logic             grant_b;
   logic [ASIZE-1:0] sel_addr;
   logic [DSIZE-1:0] sel_data;

   // Ready depends only on the registered count, never on a same-cycle pop.
   assign bus.b_ready = !fifo_full;
   assign push        = bus.b_valid && !fifo_full;
   assign push_entry  = '{addr: bus.b_waddr, data: bus.b_wdata};

   wb_skid_fifo #(
      .WIDTH ($bits(wb_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (head)
   );

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state_q == ST_STALL) begin
         grant_b = !fifo_empty;
      end else if (bus.a_valid) begin
         grant_a = 1'b1;
      end else begin
         grant_b = !fifo_empty;
      end
      pop = grant_b;

      sel_addr = grant_b ? head.addr : bus.a_waddr;
      sel_data = grant_b ? head.data : bus.a_wdata;

      starve_d = (fifo_empty || grant_b) ? 4'd0 : starve_q + 4'd1;

      state_d = ST_NORMAL;
      if (state_q == ST_NORMAL && starve_d == STARVE_LIM) state_d = ST_STALL;

      // Writes to x0 still consume the slot and move addr/data, but never assert wen.
      rf_wen_d   = (grant_a || grant_b) && (sel_addr != '0);
      rf_waddr_d = (grant_a || grant_b) ? sel_addr : rf_waddr_q;
      rf_wdata_d = (grant_a || grant_b) ? sel_data : rf_wdata_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_NORMAL;
         starve_q   <= 4'd0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign bus.pipe_stall = (state_q == ST_STALL);
   assign bus.rf_wen     = rf_wen_q;
   assign bus.rf_waddr   = rf_waddr_q;
   assign bus.rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: per-source scoreboards of expected writes plus
// cycle-exact checks of stall, back-pressure, x0 suppression and asynchronous reset.
module tb_wb_port_arbiter;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      int          at;
      logic [4:0]  addr;
      logic [31:0] data;
   } bsrc_t;

   logic clk;
   logic rst;

   wb_port_arbiter_if #(.DSIZE(32), .ASIZE(5)) bus ();

   wb_port_arbiter #(
      .DSIZE      (32),
      .ASIZE      (5),
      .STARVE_MAX (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   wr_t   exp_a [$];
   wr_t   exp_b [$];
   bsrc_t b_src [$];
   int    acc_cyc [$];

   logic        stall_log [0:63];
   logic        ready_log [0:63];
   logic        wen_log   [0:63];
   logic [4:0]  waddr_log [0:63];
   logic [31:0] wdata_log [0:63];

   int a_idx = 0;
   bit a_on  = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.a_valid = 1'b0;
      bus.a_waddr = '0;
      bus.a_wdata = '0;
      bus.b_valid = 1'b0;
      bus.b_waddr = '0;
      bus.b_wdata = '0;
   endtask

   // Addresses 1..6 belong to A traffic, 7 and above to B traffic.
   always @(negedge clk) begin
      wr_t e;
      if (!rst && bus.rf_wen) begin
         if (bus.rf_waddr >= 5'd7) begin
            check("b_write_expected", 64'(exp_b.size() > 0), 64'(1));
            if (exp_b.size() > 0) begin
               e = exp_b.pop_front();
               check("b_write_addr", 64'(bus.rf_waddr), 64'(e.addr));
               check("b_write_data", 64'(bus.rf_wdata), 64'(e.data));
            end
         end else begin
            check("a_write_expected", 64'(exp_a.size() > 0), 64'(1));
            if (exp_a.size() > 0) begin
               e = exp_a.pop_front();
               check("a_write_addr", 64'(bus.rf_waddr), 64'(e.addr));
               check("a_write_data", 64'(bus.rf_wdata), 64'(e.data));
            end
         end
      end
   end

   // Upstream pipeline (holds A while stalled) plus B source (holds valid until ready).
   task automatic run(input int n);
      wr_t w;
      acc_cyc.delete();
      for (int c = 0; c < n; c++) begin
         if (a_on) begin
            bus.a_valid = 1'b1;
            bus.a_waddr = 5'(1 + (a_idx % 6));
            bus.a_wdata = 32'hA000_0000 + 32'(a_idx);
            if (!bus.pipe_stall) begin
               w.addr = bus.a_waddr;
               w.data = bus.a_wdata;
               exp_a.push_back(w);
               a_idx++;
            end
         end else begin
            bus.a_valid = 1'b0;
         end

         if (b_src.size() > 0 && c >= b_src[0].at) begin
            bus.b_valid = 1'b1;
            bus.b_waddr = b_src[0].addr;
            bus.b_wdata = b_src[0].data;
            if (bus.b_ready) begin
               if (b_src[0].addr != 5'd0) begin
                  w.addr = b_src[0].addr;
                  w.data = b_src[0].data;
                  exp_b.push_back(w);
               end
               acc_cyc.push_back(c);
               void'(b_src.pop_front());
            end
         end else begin
            bus.b_valid = 1'b0;
         end

         stall_log[c] = bus.pipe_stall;
         ready_log[c] = bus.b_ready;
         wen_log[c]   = bus.rf_wen;
         waddr_log[c] = bus.rf_waddr;
         wdata_log[c] = bus.rf_wdata;
         step();
      end
      idle();
   endtask

   initial begin
      int a0;
      int n_stall;
      int n_wen;

      // Power-on reset values.
      idle();
      rst = 1'b1;
      #12;
      check("rst_rf_wen",     64'(bus.rf_wen),     64'(0));
      check("rst_rf_waddr",   64'(bus.rf_waddr),   64'(0));
      check("rst_rf_wdata",   64'(bus.rf_wdata),   64'(0));
      check("rst_pipe_stall", 64'(bus.pipe_stall), 64'(0));
      check("rst_b_ready",    64'(bus.b_ready),    64'(1));
      step();
      rst = 1'b0;
      step();

      // A only: one-cycle latency, then outputs hold with wen low.
      bus.a_valid = 1'b1;
      bus.a_waddr = 5'd3;
      bus.a_wdata = 32'hDEAD_BEEF;
      exp_a.push_back('{addr: 5'd3, data: 32'hDEAD_BEEF});
      step();
      idle();
      check("a_only_wen",   64'(bus.rf_wen),   64'(1));
      check("a_only_waddr", 64'(bus.rf_waddr), 64'(3));
      check("a_only_wdata", 64'(bus.rf_wdata), 64'(32'hDEAD_BEEF));
      step();
      check("idle_wen",        64'(bus.rf_wen),   64'(0));
      check("idle_waddr_hold", 64'(bus.rf_waddr), 64'(3));
      check("idle_wdata_hold", 64'(bus.rf_wdata), 64'(32'hDEAD_BEEF));

      // A to x0: no write, but address/data still move.
      bus.a_valid = 1'b1;
      bus.a_waddr = 5'd0;
      bus.a_wdata = 32'h5555_5555;
      step();
      idle();
      check("a_x0_wen",   64'(bus.rf_wen),   64'(0));
      check("a_x0_waddr", 64'(bus.rf_waddr), 64'(0));
      check("a_x0_wdata", 64'(bus.rf_wdata), 64'(32'h5555_5555));
      step();

      // B only: accepted at c0, written at c2, nothing after.
      a_on = 1'b0;
      b_src.push_back('{0, 5'd7, 32'h0000_0012});
      run(5);
      check("b_only_accept_cyc", 64'(acc_cyc[0]), 64'(0));
      check("b_only_no_bypass",  64'(wen_log[1]), 64'(0));
      check("b_only_wen",        64'(wen_log[2]), 64'(1));
      check("b_only_waddr",      64'(waddr_log[2]), 64'(7));
      check("b_only_wdata",      64'(wdata_log[2]), 64'(32'h12));
      check("b_only_drained",    64'(wen_log[3]), 64'(0));

      // Starvation: A every cycle, one B pending; exactly one stall at c5.
      a_on = 1'b1;
      a0   = a_idx;
      b_src.push_back('{0, 5'd9, 32'hB0B0_0001});
      run(12);
      n_stall = 0;
      for (int c = 0; c < 12; c++) n_stall += int'(stall_log[c]);
      check("starve_stall_count", 64'(n_stall),      64'(1));
      check("starve_stall_cyc",   64'(stall_log[5]), 64'(1));
      check("starve_b_wen",       64'(wen_log[6]),   64'(1));
      check("starve_b_waddr",     64'(waddr_log[6]), 64'(9));
      check("starve_held_a_wen",  64'(wen_log[7]),   64'(1));
      check("starve_held_a_addr", 64'(waddr_log[7]), 64'(1 + ((a0 + 5) % 6)));
      a_on = 1'b0;
      step();
      step();

      // Back-pressure: three B pushes under continuous A.
      a_on = 1'b1;
      b_src.push_back('{0, 5'd10, 32'hB1B1_0010});
      b_src.push_back('{0, 5'd11, 32'hB1B1_0011});
      b_src.push_back('{0, 5'd12, 32'hB1B1_0012});
      run(20);
      check("bp_accepts",      64'(acc_cyc.size()), 64'(3));
      check("bp_accept0_cyc",  64'(acc_cyc[0]),     64'(0));
      check("bp_accept1_cyc",  64'(acc_cyc[1]),     64'(1));
      check("bp_ready_full",   64'(ready_log[2]),   64'(0));
      check("bp_accept2_cyc",  64'(acc_cyc[2]),     64'(6));
      n_stall = 0;
      for (int c = 0; c < 20; c++) n_stall += int'(stall_log[c]);
      check("bp_stall_count",  64'(n_stall),        64'(3));
      check("bp_stall_period", 64'({stall_log[5], stall_log[10], stall_log[15]}), 64'(3'b111));
      check("bp_last_b_addr",  64'(waddr_log[16]),  64'(12));
      a_on = 1'b0;
      step();
      step();

      // B to x0 is popped silently; the next entry writes one cycle later.
      b_src.push_back('{0, 5'd0,  32'h0000_00CC});
      b_src.push_back('{0, 5'd13, 32'h0000_00DD});
      run(6);
      check("b_x0_wen",    64'(wen_log[2]),   64'(0));
      check("b_x0_waddr",  64'(waddr_log[2]), 64'(0));
      check("b_x0_wdata",  64'(wdata_log[2]), 64'(32'hCC));
      check("b_next_wen",  64'(wen_log[3]),   64'(1));
      check("b_next_addr", 64'(waddr_log[3]), 64'(13));
      step();

      check("a_scoreboard_drained", 64'(exp_a.size()), 64'(0));
      check("b_scoreboard_drained", 64'(exp_b.size()), 64'(0));

      // Asynchronous reset mid-cycle with two B entries queued.
      a_on = 1'b1;
      b_src.push_back('{0, 5'd14, 32'hE0E0_0014});
      b_src.push_back('{0, 5'd15, 32'hE0E0_0015});
      run(3);
      a_on = 1'b0;
      check("pre_rst_fifo_full", 64'(bus.b_ready), 64'(0));
      check("pre_rst_wen",       64'(bus.rf_wen),  64'(1));
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_wen",        64'(bus.rf_wen),     64'(0));
      check("async_rst_waddr",      64'(bus.rf_waddr),   64'(0));
      check("async_rst_wdata",      64'(bus.rf_wdata),   64'(0));
      check("async_rst_pipe_stall", 64'(bus.pipe_stall), 64'(0));
      check("async_rst_b_ready",    64'(bus.b_ready),    64'(1));
      exp_a.delete();
      exp_b.delete();
      step();
      rst = 1'b0;
      run(8);
      n_wen = 0;
      for (int c = 0; c < 8; c++) n_wen += int'(wen_log[c]);
      check("post_rst_no_writes", 64'(n_wen), 64'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

- Shares the single register-file write port between two sources:
  - the EXE→WB pipeline writeback (requester A);
  - a long-latency functional unit such as mul/div (requester B).
- Sits after the EXE/WB pipeline register and drives the register-file write port (`rf_wen`, `rf_waddr`, `rf_wdata`).
- A has priority. B results wait in a 2-entry buffer.
- A starvation counter forces a one-cycle pipeline stall so that buffered B results always drain.

## Interface
Parameters:
- `DSIZE`, default 32: data width. Equals the shared `` `DSIZE `` macro.
- `ASIZE`, default 5: register address width. Equals `` `ASIZE ``.
- `STARVE_MAX`, default 4: number of consecutive cycles a B result may wait before a stall is forced. Legal range 1–15.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `a_valid`, in, 1: pipeline writeback valid.
- `a_waddr`, in, ASIZE: pipeline destination register.
- `a_wdata`, in, DSIZE: pipeline result (ALU output).
- `b_valid`, in, 1: functional-unit result valid.
- `b_ready`, out, 1: arbiter can accept a B result.
- `b_waddr`, in, ASIZE: functional-unit destination register.
- `b_wdata`, in, DSIZE: functional-unit result.
- `pipe_stall`, out, 1: the upstream pipeline holds its EXE/WB register this cycle.
- `rf_wen`, out, 1: register-file write enable (registered).
- `rf_waddr`, out, ASIZE: register-file write address (registered).
- `rf_wdata`, out, DSIZE: register-file write data (registered).

## Operation
- **B handshake:** a B result is accepted when `b_valid && b_ready`. `b_ready = !fifo_full`; it is derived from registered count only, not from a same-cycle pop. An accepted result is pushed to the FIFO tail.
- **FSM states:** NORMAL and STALL. `pipe_stall = (state == STALL)`, a Moore output.
- **NORMAL, grant rules:**
  - If `a_valid`, grant A.
  - Otherwise, if the FIFO is non-empty, grant the FIFO head and pop it.
  - Otherwise, no grant.
- **STALL:** grant the FIFO head and pop it. `a_valid` is ignored; upstream holds and re-presents it next cycle. Always returns to NORMAL after one cycle.
- **Starvation counter (4 bits):**
  - Increments each cycle in which the FIFO is non-empty and the head is not granted.
  - Clears on any B grant, or when the FIFO is empty.
  - When the counter equals `STARVE_MAX` at a clock edge, the next state is STALL.
- **x0 suppression:** a granted write with waddr == 0 produces `rf_wen = 0`. The grant still consumes the slot (a B entry is still popped). `rf_waddr`/`rf_wdata` still update.
- **Ordering:** B entries retire in FIFO order. Issue logic guarantees no WAW conflict between outstanding B results and A; the arbiter performs no address compare.
- **Simultaneous push and pop on a non-full FIFO:** legal; count is unchanged.
- **Push into a full FIFO:** impossible, because ready is 0.
- **Reset:** FIFO contents are discarded, including mid-operation. Count = 0, counter = 0, state = NORMAL.

## Timing
- **Reset values:** `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `pipe_stall` = 0, `b_ready` = 1.
- **A latency:** `a_valid` in cycle t → `rf_wen`/addr/data in cycle t+1.
- **B latency:** accepted in cycle t → earliest write in cycle t+2 (FIFO has no bypass).
- **Worst case for the FIFO head:** written within `STARVE_MAX` + 2 cycles of reaching the head.
- **Write-port rate:** at most one write per cycle. A continuous A stream is interrupted by exactly one STALL cycle per `STARVE_MAX` + 1 cycles while B is pending.
- **rf outputs when no grant:** `rf_wen` = 0. `rf_waddr`/`rf_wdata` hold their previous values.

## Structure
- `DSIZE`/`ASIZE` come from the shared define file.
- FSM state encoding (NORMAL = 0, STALL = 1) is declared as localparams in the shared define file so the hazard unit can decode `pipe_stall` causes.
- One sub-module, `wb_skid_fifo`: 2-entry FIFO of {ASIZE, DSIZE}, with push/pop/full/empty/head outputs and asynchronous reset.
- The arbiter, FSM and starvation counter live in the top module.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with 2 B entries queued → all rf outputs 0 and `pipe_stall` 0 immediately; `b_ready` = 1; no writes after release.
- **A only:** `a_valid` with waddr 3, wdata 0xDEADBEEF at cycle 5 → `rf_wen` = 1, `rf_waddr` = 3, `rf_wdata` = 0xDEADBEEF at cycle 6.
- **B only:** B accepted at cycle 10 with waddr 7, wdata 0x12 → write at cycle 12; FIFO empty at cycle 12.
- **Back-pressure:** 3 back-to-back B pushes while A is continuously valid → first two accepted; `b_ready` = 0 on the third; third accepted after the first pop.
- **Starvation (`STARVE_MAX` = 4):** A valid every cycle, one B entry pending from cycle 0 → `pipe_stall` = 1 in exactly one cycle, B written the following cycle, held A written next.
- **x0 suppression:** `a_valid` with waddr 0 → `rf_wen` = 0. A B entry with waddr 0 is popped without a write, and the next B entry writes one cycle later.
